onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 12, is the word-address width of the shared single-port RAM (4096 words).
- REQ-002: Parameter DATA_W, default 32, is the data width; BE_W = DATA_W/8 is the byte-enable width.
- REQ-003: clk  input  1  is the single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  is the asynchronous, active-high reset.
- REQ-005: mN_address  input  ADDR_W  is the requester word address, for N = 0, 1 throughout.
- REQ-006: mN_byteenable  input  BE_W  is the write byte lanes.
- REQ-007: mN_read, mN_write  input  1 each  are the access requests; both high in one cycle is illegal.
- REQ-008: mN_writedata  input  DATA_W  is the write data.
- REQ-009: mN_lock  input  1  holds the grant across back-to-back accesses (read-modify-write).
- REQ-010: mN_waitrequest  output  1  is high when the request is not accepted this cycle.
- REQ-011: mN_readdata  output  DATA_W  is the returned read data.
- REQ-012: mN_readdatavalid  output  1  is a one-cycle pulse qualifying mN_readdata.
- REQ-013: mem_address, mem_byteenable, mem_writedata  outputs  ADDR_W / BE_W / DATA_W  drive the RAM port.
- REQ-014: mem_chipselect, mem_write, mem_clken  outputs  1 each  drive the RAM controls.
- REQ-015: mem_readdata  input  DATA_W  is the RAM output, valid the cycle after the address is clocked.

Function
- REQ-016: The FSM SHALL have states IDLE, LOCK0 and LOCK1, plus a registered last_grant bit.
- REQ-017: In IDLE with one requester active, that requester SHALL be granted in the same cycle.
- REQ-018: In IDLE with both active, the requester not equal to last_grant SHALL be granted (round-robin).
- REQ-019: A granted requester SHALL see mN_waitrequest = 0 in the grant cycle; every other active requester SHALL see 1.
- REQ-020: An idle requester's waitrequest SHALL be 0 (don't-care to the requester).
- REQ-021: On a grant, the mem_* outputs SHALL be driven combinationally from the granted master; mem_chipselect = 1 and mem_write = granted mN_write.
- REQ-022: mem_byteenable SHALL equal mN_byteenable on writes and all-ones on reads.
- REQ-023: With no grant, mem_chipselect and mem_write SHALL be 0; the address/data outputs hold their previous values.
- REQ-024: mem_clken SHALL be 1 whenever reset is low.
- REQ-025: last_grant SHALL update to N at each accepted access by N.
- REQ-026: An accepted access with mN_lock = 1 SHALL move the FSM to LOCKN.
- REQ-027: In LOCKN only master N is eligible; the other master SHALL be held in waitrequest.
- REQ-028: LOCKN SHALL return to IDLE after the first accepted access with mN_lock = 0, or on a cycle where N asserts neither read nor write.
- REQ-029: An accepted read SHALL set a registered rd_pending with rd_owner = N.
- REQ-030: In the following cycle, m{rd_owner}_readdatavalid SHALL be 1 and mN_readdata = mem_readdata, giving a fixed read latency of 1.
- REQ-031: Back-to-back reads SHALL be accepted every cycle with one readdatavalid per read, in order.
- REQ-032: Write acceptance SHALL be single-cycle, with no readdatavalid.
- REQ-033: A read issued the cycle after a write to the same address SHALL return the new data.

Reset
- REQ-034: While reset is high: FSM = IDLE, last_grant = 1 (m0 wins the first tie), rd_pending = 0, all readdatavalid = 0, mem_chipselect = mem_write = mem_clken = 0, mem_address/byteenable/writedata = 0, mN_readdata = 0.
- REQ-035: A read accepted in the cycle reset asserts SHALL produce no readdatavalid; no lock survives reset.

Verification
- REQ-036: Solo traffic: m0 writes 0xDEADBEEF to 0x010 with byteenable 0xF, then reads 0x010 -> waitrequest never high; readdatavalid on cycle read+1 with data 0xDEADBEEF.
- REQ-037: Tie: both read every cycle after reset -> grants alternate m0, m1, m0, ...; each master sees exactly one readdatavalid per accepted read.
- REQ-038: Lock: m1 lock-reads 0x020, then writes 0x020 with lock = 0, while m0 requests continuously -> m0 waitrequest = 1 for both cycles and is granted on the third.
- REQ-039: Byte lanes: write 0xFFFFFFFF, then write 0x00000000 with byteenable 0x2, then read -> 0xFFFF00FF.
- REQ-040: Reset mid-read: assert reset in the cycle m0's read is accepted -> no readdatavalid; after release the first tie goes to m0.
- REQ-041: Address wrap: access 0xFFF then 0x000 -> distinct data retained; no aliasing.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for a shared single-port on-chip RAM with round-robin
// tie-breaking, lock-based grant holding and a fixed one-cycle read return path.
module onchip_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic                  m0_lock,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic                  m1_lock,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic                r_lastGrant;
   logic                r_rdPending;
   logic                r_rdOwner;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [BE_W-1:0]     r_memBe;
   logic [DATA_W-1:0]   r_memWdata;

   logic                w_act0;
   logic                w_act1;
   logic                w_grant0;
   logic                w_grant1;
   logic [ADDR_W-1:0]   w_memAddr;
   logic [BE_W-1:0]     w_memBe;
   logic [DATA_W-1:0]   w_memWdata;

   assign w_act0 = m0_read | m0_write;
   assign w_act1 = m1_read | m1_write;

   // Grants are suppressed while reset is high so nothing reaches the RAM or the read pipe.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!reset) begin
         case (r_state)
            IDLE: begin
               if (w_act0 && w_act1) begin
                  w_grant0 = r_lastGrant;
                  w_grant1 = ~r_lastGrant;
               end else begin
                  w_grant0 = w_act0;
                  w_grant1 = w_act1;
               end
            end
            LOCK0:   w_grant0 = w_act0;
            LOCK1:   w_grant1 = w_act1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant0 && m0_lock)
               w_nextState = LOCK0;
            else if (w_grant1 && m1_lock)
               w_nextState = LOCK1;
         end
         LOCK0: begin
            if (!w_act0 || (w_grant0 && !m0_lock))
               w_nextState = IDLE;
         end
         LOCK1: begin
            if (!w_act1 || (w_grant1 && !m1_lock))
               w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Without a grant the RAM port keeps presenting the last address/data.
   always_comb begin
      w_memAddr  = r_memAddr;
      w_memBe    = r_memBe;
      w_memWdata = r_memWdata;
      if (w_grant0) begin
         w_memAddr  = m0_address;
         w_memBe    = m0_write ? m0_byteenable : {BE_W{1'b1}};
         w_memWdata = m0_writedata;
      end else if (w_grant1) begin
         w_memAddr  = m1_address;
         w_memBe    = m1_write ? m1_byteenable : {BE_W{1'b1}};
         w_memWdata = m1_writedata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_lastGrant <= 1'b1;
         r_rdPending <= 1'b0;
         r_rdOwner   <= 1'b0;
         r_memAddr   <= '0;
         r_memBe     <= '0;
         r_memWdata  <= '0;
      end else begin
         r_state     <= w_nextState;
         r_rdPending <= (w_grant0 & m0_read) | (w_grant1 & m1_read);
         r_rdOwner   <= w_grant1;
         r_memAddr   <= w_memAddr;
         r_memBe     <= w_memBe;
         r_memWdata  <= w_memWdata;
         if (w_grant0)
            r_lastGrant <= 1'b0;
         else if (w_grant1)
            r_lastGrant <= 1'b1;
      end
   end

   assign mem_address    = w_memAddr;
   assign mem_byteenable = w_memBe;
   assign mem_writedata  = w_memWdata;
   assign mem_chipselect = w_grant0 | w_grant1;
   assign mem_write      = (w_grant0 & m0_write) | (w_grant1 & m1_write);
   assign mem_clken      = ~reset;

   assign m0_waitrequest = w_act0 & ~w_grant0;
   assign m1_waitrequest = w_act1 & ~w_grant1;

   assign m0_readdatavalid = r_rdPending & ~r_rdOwner;
   assign m1_readdatavalid = r_rdPending &  r_rdOwner;
   assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed testbench for onchip_mem_arbiter with a byte-lane RAM model
// returning read data one cycle after the address is clocked.
module tb_onchip_mem_arbiter;

   logic          clk;
   logic          reset;
   logic [11:0]   m0Address, m1Address;
   logic [3:0]    m0Be, m1Be;
   logic          m0Read, m0Write, m0Lock;
   logic          m1Read, m1Write, m1Lock;
   logic [31:0]   m0Wdata, m1Wdata;
   logic          m0Wait, m1Wait;
   logic [31:0]   m0Rdata, m1Rdata;
   logic          m0Rdv, m1Rdv;
   logic [11:0]   memAddress;
   logic [3:0]    memBe;
   logic [31:0]   memWdata;
   logic          memCs, memWrite, memClken;
   logic [31:0]   memRdata;

   logic [31:0]   ram [0:4095];
   logic          ramClear;
   int            checks;
   int            errors;

   onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0Address),
      .m0_byteenable    (m0Be),
      .m0_read          (m0Read),
      .m0_write         (m0Write),
      .m0_writedata     (m0Wdata),
      .m0_lock          (m0Lock),
      .m0_waitrequest   (m0Wait),
      .m0_readdata      (m0Rdata),
      .m0_readdatavalid (m0Rdv),
      .m1_address       (m1Address),
      .m1_byteenable    (m1Be),
      .m1_read          (m1Read),
      .m1_write         (m1Write),
      .m1_writedata     (m1Wdata),
      .m1_lock          (m1Lock),
      .m1_waitrequest   (m1Wait),
      .m1_readdata      (m1Rdata),
      .m1_readdatavalid (m1Rdv),
      .mem_address      (memAddress),
      .mem_byteenable   (memBe),
      .mem_writedata    (memWdata),
      .mem_chipselect   (memCs),
      .mem_write        (memWrite),
      .mem_clken        (memClken),
      .mem_readdata     (memRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: read returns pre-write contents, lanes written per byteenable.
   always @(posedge clk) begin
      if (ramClear) begin
         for (int i = 0; i < 4096; i++)
            ram[i] <= 32'h0;
      end else if (memCs && memClken) begin
         memRdata <= ram[memAddress];
         if (memWrite)
            for (int b = 0; b < 4; b++)
               if (memBe[b])
                  ram[memAddress][b*8 +: 8] <= memWdata[b*8 +: 8];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int m, input logic rd, input logic wr, input logic lk,
                                input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd);
      if (m == 0) begin
         m0Read = rd; m0Write = wr; m0Lock = lk; m0Address = a; m0Be = be; m0Wdata = wd;
      end else begin
         m1Read = rd; m1Write = wr; m1Lock = lk; m1Address = a; m1Be = be; m1Wdata = wd;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleAll();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
   endtask

   task automatic writeM0(input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, a, be, wd);
      #1;
      checkOutput("wr_wait", {31'b0, m0Wait}, 32'h0);
      tick();
      checkOutput("wr_no_rdv", {31'b0, m0Rdv}, 32'h0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      ramClear = 1'b1;
      idleAll();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h005, 4'hF, 32'h0);
      tick();
      ramClear = 1'b0;
      tick();
      checkOutput("rst_cs",     {31'b0, memCs},    32'h0);
      checkOutput("rst_clken",  {31'b0, memClken}, 32'h0);
      checkOutput("rst_memwr",  {31'b0, memWrite}, 32'h0);
      checkOutput("rst_addr",   {20'b0, memAddress}, 32'h0);
      checkOutput("rst_be_wd",  {28'b0, memBe} | memWdata, 32'h0);
      checkOutput("rst_rdv",    {30'b0, m1Rdv, m0Rdv}, 32'h0);
      checkOutput("rst_rdata",  m0Rdata | m1Rdata, 32'h0);

      reset = 1'b0;
      idleAll();
      #1;
      checkOutput("idle_cs", {31'b0, memCs}, 32'h0);
      checkOutput("idle_clken", {31'b0, memClken}, 32'h1);

      // Solo write then read of the same word
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 12'h010, 4'hF, 32'hDEADBEEF);
      #1;
      checkOutput("solo_wr_wait", {31'b0, m0Wait}, 32'h0);
      checkOutput("solo_wr_cs",   {30'b0, memCs, memWrite}, 32'h3);
      checkOutput("solo_wr_addr", {20'b0, memAddress}, 32'h010);
      checkOutput("solo_wr_data", memWdata, 32'hDEADBEEF);
      checkOutput("solo_wr_be",   {28'b0, memBe}, 32'hF);
      tick();
      checkOutput("solo_wr_rdv",  {31'b0, m0Rdv}, 32'h0);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 32'h0);
      #1;
      checkOutput("solo_rd_wait", {31'b0, m0Wait}, 32'h0);
      checkOutput("solo_rd_memwr", {31'b0, memWrite}, 32'h0);
      checkOutput("solo_rd_be",   {28'b0, memBe}, 32'hF);
      tick();
      idleAll();
      checkOutput("solo_rd_rdv",  {31'b0, m0Rdv}, 32'h1);
      checkOutput("solo_rd_data", m0Rdata, 32'hDEADBEEF);
      #1;
      checkOutput("hold_cs",   {31'b0, memCs}, 32'h0);
      checkOutput("hold_addr", {20'b0, memAddress}, 32'h010);
      tick();
      checkOutput("solo_rdv_once", {31'b0, m0Rdv}, 32'h0);

      // Lock: last grant is m0, so m1 wins the tie and then holds the RAM
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h030, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, 1'b1, 12'h020, 4'h0, 32'h0);
      #1;
      checkOutput("lock1_waits", {30'b0, m1Wait, m0Wait}, 32'h1);
      checkOutput("lock1_addr",  {20'b0, memAddress}, 32'h020);
      tick();
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 12'h020, 4'hF, 32'h12345678);
      checkOutput("lock1_rdv",   {30'b0, m1Rdv, m0Rdv}, 32'h2);
      checkOutput("lock1_rdata", m1Rdata, 32'h0);
      #1;
      checkOutput("lock2_waits", {30'b0, m1Wait, m0Wait}, 32'h1);
      checkOutput("lock2_memwr", {31'b0, memWrite}, 32'h1);
      tick();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      #1;
      checkOutput("lock3_waits", {30'b0, m1Wait, m0Wait}, 32'h0);
      checkOutput("lock3_addr",  {20'b0, memAddress}, 32'h030);
      tick();
      idleAll();
      checkOutput("lock3_rdv",   {30'b0, m1Rdv, m0Rdv}, 32'h1);
      checkOutput("lock3_rdata", m0Rdata, 32'h0);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h020, 4'h0, 32'h0);
      tick();
      idleAll();
      checkOutput("lock_wr_data", m0Rdata, 32'h12345678);

      // Byte lanes
      writeM0(12'h040, 4'hF, 32'hFFFFFFFF);
      writeM0(12'h040, 4'h2, 32'h00000000);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h040, 4'h0, 32'h0);
      tick();
      idleAll();
      checkOutput("lanes_data", m0Rdata, 32'hFFFF00FF);

      // Address extremes stay distinct; reads issued back-to-back
      writeM0(12'hFFF, 4'hF, 32'hAAAA5555);
      writeM0(12'h000, 4'hF, 32'h1234ABCD);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'hFFF, 4'h0, 32'h0);
      tick();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
      checkOutput("wrap_fff", m0Rdata, 32'hAAAA5555);
      tick();
      idleAll();
      checkOutput("wrap_000_rdv", {31'b0, m0Rdv}, 32'h1);
      checkOutput("wrap_000", m0Rdata, 32'h1234ABCD);
      tick();

      // Reset arrives while m0's read is being accepted
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 32'h0);
      #1;
      checkOutput("rstrd_wait", {31'b0, m0Wait}, 32'h0);
      #2;
      reset = 1'b1;
      tick();
      checkOutput("rstrd_rdv", {31'b0, m0Rdv}, 32'h0);
      checkOutput("rstrd_cs",  {31'b0, memCs}, 32'h0);
      #1;
      reset = 1'b0;

      // Tie after reset: alternate starting with m0
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h040, 4'h0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         #1;
         checkOutput($sformatf("tie_wait_%0d", i), {30'b0, m1Wait, m0Wait},
                     (i % 2 == 0) ? 32'h2 : 32'h1);
         tick();
         checkOutput($sformatf("tie_rdv_%0d", i), {30'b0, m1Rdv, m0Rdv},
                     (i % 2 == 0) ? 32'h1 : 32'h2);
         checkOutput($sformatf("tie_data_%0d", i), m0Rdata | m1Rdata,
                     (i % 2 == 0) ? 32'hDEADBEEF : 32'hFFFF00FF);
      end
      idleAll();
      tick();
      checkOutput("tie_end_rdv", {30'b0, m1Rdv, m0Rdv}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
